// File: rtl/score_display.sv
// Pong score keeper: two BCD scores, winner detect, 4-digit 7-seg mux.
// Optional SCORE_LZB_EN: blank a player's tens digit when it is zero.
module score_display #(
  parameter int REFRESH_BITS = 18,
  parameter int WIN_SCORE    = 11,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       score_l,
  input  logic       score_r,
  input  logic       clr,
  output logic       game_over,
  output logic       winner,
  output logic [6:0] seg,
  output logic [3:0] av
);

  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [3:0] WIN_T = 4'(WIN_SCORE / 10);
  localparam logic [3:0] WIN_U = 4'(WIN_SCORE % 10);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [BW-1:0] B_ONE = BW'(1);
  localparam logic [REFRESH_BITS-1:0] C_ONE = REFRESH_BITS'(1);
  localparam logic [6:0] BLANK = 7'h7F;

  logic l_s, l_h, r_s, r_h;
  logic edge_l, edge_r;
  logic [3:0] lt, lu, rt, ru;
  logic [3:0] nlt, nlu, nrt, nru;
  logic hit_l, hit_r;
  logic [REFRESH_BITS-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic phase;
  logic [1:0] sel;
  logic [3:0] dig;
  logic [3:0] av_n;
  logic tens_pos, left_pos, blank;

  assign edge_l = l_s & ~l_h;
  assign edge_r = r_s & ~r_h;

  // Input synchronisers and rising-edge history
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      l_s <= 1'b1;
      l_h <= 1'b1;
      r_s <= 1'b1;
      r_h <= 1'b1;
    end else begin
      l_s <= score_l;
      l_h <= l_s;
      r_s <= score_r;
      r_h <= r_s;
    end
  end

  // Next BCD scores and win detection
  always_comb begin
    nlt = lt;
    nlu = lu;
    nrt = rt;
    nru = ru;
    if (edge_l) begin
      if (lu == 4'd9) begin
        nlu = 4'd0;
        nlt = (lt == 4'd9) ? 4'd0 : lt + 4'd1;
      end else begin
        nlu = lu + 4'd1;
      end
    end
    if (edge_r) begin
      if (ru == 4'd9) begin
        nru = 4'd0;
        nrt = (rt == 4'd9) ? 4'd0 : rt + 4'd1;
      end else begin
        nru = ru + 4'd1;
      end
    end
    hit_l = edge_l && nlt == WIN_T && nlu == WIN_U;
    hit_r = edge_r && nrt == WIN_T && nru == WIN_U;
  end

  // Score registers, game_over and winner
  always_ff @(posedge clk_100MHz) begin
    if (!reset || clr) begin
      lt <= 4'd0;
      lu <= 4'd0;
      rt <= 4'd0;
      ru <= 4'd0;
      game_over <= 1'b0;
      winner <= 1'b0;
    end else if (!game_over) begin
      lt <= nlt;
      lu <= nlu;
      rt <= nrt;
      ru <= nru;
      if (hit_l || hit_r) begin
        game_over <= 1'b1;
        winner <= ~hit_l;
      end
    end
  end

  // Free-running digit refresh counter
  always_ff @(posedge clk_100MHz) begin
    if (!reset) cnt <= '0;
    else cnt <= cnt + C_ONE;
  end

  // Blink phase timer, restarts in the on phase
  always_ff @(posedge clk_100MHz) begin
    if (!reset || !game_over) begin
      bcnt <= '0;
      phase <= 1'b0;
    end else if (bcnt == B_LAST) begin
      bcnt <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + B_ONE;
    end
  end

  // Digit select, anode pattern and blanking
  always_comb begin
    sel = cnt[REFRESH_BITS-1 -: 2];
    dig = ru;
    av_n = 4'b1110;
    tens_pos = 1'b0;
    left_pos = 1'b0;
    unique case (sel)
      2'd0: begin dig = ru; av_n = 4'b1110; end
      2'd1: begin dig = rt; av_n = 4'b1101; tens_pos = 1'b1; end
      2'd2: begin dig = lu; av_n = 4'b1011; left_pos = 1'b1; end
      2'd3: begin
        dig = lt;
        av_n = 4'b0111;
        tens_pos = 1'b1;
        left_pos = 1'b1;
      end
    endcase
    blank = game_over && phase && (left_pos == ~winner);
`ifdef SCORE_LZB_EN
    if (tens_pos && dig == 4'd0) blank = 1'b1;
`else
    if (tens_pos && 1'b0) blank = 1'b1;
`endif
  end

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    s = BLANK;
    case (d)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = BLANK;
    endcase
    return s;
  endfunction

  // Registered segment and anode drive
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      seg <= BLANK;
      av <= 4'hF;
    end else begin
      seg <= blank ? BLANK : decode(dig);
      av <= av_n;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: integer-score model, random and directed stimulus.
// Honours SCORE_LZB_EN when defined for the build.
module tb_score_display;
  localparam int RB = 4;
  localparam int WIN = 15;
  localparam int BC = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic score_l = 1'b0;
  logic score_r = 1'b0;
  logic clr = 1'b0;
  logic game_over, winner;
  logic [6:0] seg;
  logic [3:0] av;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  score_display #(
    .REFRESH_BITS(RB),
    .WIN_SCORE(WIN),
    .BLINK_CYCLES(BC)
  ) dut (
    .clk_100MHz(clk),
    .reset(reset),
    .score_l(score_l),
    .score_r(score_r),
    .clr(clr),
    .game_over(game_over),
    .winner(winner),
    .seg(seg),
    .av(av)
  );

  logic [6:0] segtab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  int m_sl = 0, m_sr = 0, m_bc = 0, m_cnt = 0;
  bit m_go = 0, m_win = 0, m_ph = 0;
  bit h1l = 1, h2l = 1, h1r = 1, h2r = 1;
  logic [6:0] m_seg = 7'h7F;
  logic [3:0] m_av = 4'hF;

  // Reference model: integer scores, one update per clock edge
  always @(posedge clk) begin : model
    bit el, er, blank, old_go;
    int sel, val;
    if (!reset) begin
      m_sl = 0; m_sr = 0; m_go = 0; m_win = 0;
      m_bc = 0; m_ph = 0; m_cnt = 0;
      h1l = 1; h2l = 1; h1r = 1; h2r = 1;
      m_seg = 7'h7F; m_av = 4'hF;
    end else begin
      el = h1l && !h2l;
      er = h1r && !h2r;
      sel = m_cnt / (1 << (RB - 2));
      case (sel)
        0: val = m_sr % 10;
        1: val = m_sr / 10;
        2: val = m_sl % 10;
        default: val = m_sl / 10;
      endcase
      blank = m_go && m_ph && ((sel >= 2) == (m_win == 0));
`ifdef SCORE_LZB_EN
      if ((sel % 2) == 1 && val == 0) blank = 1;
`endif
      m_seg = blank ? 7'h7F : segtab[val];
      m_av = 4'(~(1 << sel));
      old_go = m_go;
      if (clr) begin
        m_sl = 0; m_sr = 0; m_go = 0; m_win = 0;
      end else if (!m_go) begin
        if (el) m_sl = (m_sl + 1) % 100;
        if (er) m_sr = (m_sr + 1) % 100;
        if ((el && m_sl == WIN) || (er && m_sr == WIN)) begin
          m_go = 1;
          m_win = !(el && m_sl == WIN);
        end
      end
      if (!old_go) begin
        m_bc = 0; m_ph = 0;
      end else if (m_bc == BC - 1) begin
        m_bc = 0; m_ph = !m_ph;
      end else begin
        m_bc = m_bc + 1;
      end
      m_cnt = (m_cnt + 1) % (1 << RB);
      h2l = h1l; h1l = score_l;
      h2r = h1r; h1r = score_r;
    end
  end

  task automatic chk(input string name, input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    chk("seg", {1'b0, seg}, {1'b0, m_seg});
    chk("av", {4'b0, av}, {4'b0, m_av});
    chk("game_over", {7'b0, game_over}, {7'b0, m_go});
    chk("winner", {7'b0, winner}, {7'b0, m_win});
  endtask

  task automatic wait_digit(input logic [3:0] pat, input logic [6:0] exp,
                            input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 24 && !found; i++) begin
      step();
      if (av == pat) found = 1;
    end
    if (found) begin
      chk(name, {1'b0, seg}, {1'b0, exp});
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: anode %b never seen, last av %b", name, pat, av);
    end
  endtask

  task automatic pulse(input bit l, input bit r);
    score_l = l;
    score_r = r;
    step();
    score_l = 0;
    score_r = 0;
    step();
    step();
  endtask

  initial begin
    reset = 0;
    score_l = 1;
    repeat (3) step();
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_av", {4'b0, av}, 8'h0F);
    chk("rst_go", {7'b0, game_over}, 8'h00);

    reset = 1;
    repeat (20) step();
    score_l = 0;
    repeat (2) step();
    score_l = 1;
    repeat (100) step();
    chk("hold_model_l", 8'(m_sl), 8'd1);
    wait_digit(4'b1011, 7'b1111001, "hold_l_units");
`ifdef SCORE_LZB_EN
    wait_digit(4'b0111, 7'h7F, "hold_l_tens");
`else
    wait_digit(4'b0111, 7'b1000000, "hold_l_tens");
`endif
    wait_digit(4'b1110, 7'b1000000, "hold_r_units");
    score_l = 0;

    repeat (10) pulse(0, 1);
    wait_digit(4'b1101, 7'b1111001, "r10_tens");
    wait_digit(4'b1110, 7'b1000000, "r10_units");
    pulse(0, 1);
    wait_digit(4'b1110, 7'b1111001, "r11_units");

    for (int i = 0; i < 3000; i++) begin
      score_l = ($urandom_range(0, 2) == 0);
      score_r = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 149) == 0);
      reset = !($urandom_range(0, 599) == 0);
      step();
    end
    score_l = 0;
    score_r = 0;
    clr = 0;
    reset = 1;
    repeat (3) step();
    clr = 1;
    step();
    clr = 0;
    step();

    repeat (WIN - 1) pulse(1, 1);
    chk("tie_go", {7'b0, game_over}, 8'h00);
    pulse(1, 1);
    chk("tie_go_hi", {7'b0, game_over}, 8'h01);
    chk("tie_winner", {7'b0, winner}, 8'h00);
    chk("tie_model_r", 8'(m_sr), 8'(WIN));
    pulse(1, 0);
    pulse(0, 1);
    chk("frozen_l", 8'(m_sl), 8'(WIN));
    repeat (40) step();

    score_r = 1;
    step();
    score_r = 0;
    clr = 1;
    step();
    clr = 0;
    step();
    chk("clr_go", {7'b0, game_over}, 8'h00);
    wait_digit(4'b1110, 7'b1000000, "clr_r_units");

    repeat (12) pulse(1, 0);
    repeat (7) pulse(0, 1);
    wait_digit(4'b1110, 7'b1111000, "s1207_d0");
`ifdef SCORE_LZB_EN
    wait_digit(4'b1101, 7'h7F, "s1207_d1");
`else
    wait_digit(4'b1101, 7'b1000000, "s1207_d1");
`endif
    wait_digit(4'b1011, 7'b0100100, "s1207_d2");
    wait_digit(4'b0111, 7'b1111001, "s1207_d3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
